multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 opcode  input  6  instr[31:26] from the instruction register; sampled only in DECODE and MEMADR.
REQ-004 PCWrite  output  1  unconditional PC write enable.
REQ-005 PCWriteCond  output  1  PC write enable qualified by ALU Zero (beq).
REQ-006 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-007 MemRead  output  1  memory read enable.
REQ-008 MemWrite  output  1  memory write enable.
REQ-009 MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR.
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 PCSource  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 ALUOp1  output  1  ALUOp MSB, driven to the ALU_control block.
REQ-013 ALUOp0  output  1  ALUOp LSB, driven to the ALU_control block.
REQ-014 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
REQ-016 RegWrite  output  1  register file write enable.
REQ-017 RegDst  output  1  write register select: 0 = rt, 1 = rd.
REQ-018 state  output  4  current state encoding, for debug.
REQ-019 illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-020 Moore FSM; state register SHALL be the only storage.
- All outputs except illegal_op SHALL be a pure combinational decode of state.
- Any output not listed for a state SHALL be 0.
REQ-021 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9.
REQ-022 FETCH outputs: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00.
- Next state: DECODE.
REQ-023 DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- Next state by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXEC; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; any other opcode -> FETCH.
REQ-024 MEMADR outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- Next state: lw -> MEMRD; sw -> MEMWR.
REQ-025 MEMRD outputs: MemRead=1, IorD=1. Next state: MEMWB.
REQ-026 MEMWB outputs: RegWrite=1, MemtoReg=1, RegDst=0. Next state: FETCH.
REQ-027 MEMWR outputs: MemWrite=1, IorD=1. Next state: FETCH.
REQ-028 EXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: RTYPEWB.
REQ-029 RTYPEWB outputs: RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
REQ-030 BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state: FETCH.
REQ-031 JUMP outputs: PCWrite=1, PCSource=10. Next state: FETCH.
REQ-032 Instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
REQ-033 illegal_op SHALL be 1 only in the DECODE cycle where the opcode is unsupported, and 0 otherwise.
REQ-034 ALUOp1/ALUOp0 SHALL never both be 1 in any state.
REQ-035 State codes 10-15 are unreachable; if entered, the next clock SHALL return the FSM to FETCH with all outputs 0 for that cycle.
REQ-036 MemRead and MemWrite SHALL never both be 1 in any state.
REQ-037 opcode changes outside DECODE and MEMADR SHALL have no effect.

Reset
REQ-038 Reset assertion SHALL force state=FETCH immediately, without waiting for clk, including mid-instruction.
- Outputs then SHALL equal the REQ-022 FETCH values; illegal_op=0.
REQ-039 While reset is held, the FSM SHALL remain in FETCH.
REQ-040 First rising edge after reset deassertion SHALL advance to DECODE.

Verification
REQ-041 lw: reset, release, opcode=100011 -> states 0,1,2,3,4,0; MEMWB shows RegWrite=1, MemtoReg=1.
REQ-042 sw: opcode=101011 -> states 0,1,2,5,0; MEMWR shows MemWrite=1, IorD=1, RegWrite=0.
REQ-043 R-type then beq: opcode=000000 -> EXEC shows ALUOp1=1, ALUOp0=0; next instruction opcode=000100 -> BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-044 j and illegal: opcode=000010 -> states 0,1,9,0 with PCSource=10; opcode=111111 -> states 0,1,0 with illegal_op=1 for exactly the DECODE cycle.
REQ-045 Async reset: assert reset between clock edges while in MEMRD -> state=0 and MemRead=1, IRWrite=1, PCWrite=1 before the next edge.
REQ-046 Opcode isolation: in lw, change opcode to 101011 during MEMRD -> path unaffected; MEMWB is still reached.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control unit for a multicycle MIPS-style datapath. It is a Moore FSM
//   whose only storage is the 4-bit state register. Every datapath control
//   line is a combinational decode of the current state. The one exception is
//   illegal_op, which also looks at opcode while the FSM is in DECODE.
//
// Ports
//   clk          in   1  single clock, rising-edge active
//   reset        in   1  asynchronous, active-high reset (forces FETCH)
//   opcode       in   6  instr[31:26]; only looked at in DECODE and MEMADR
//   PCWrite      out  1  unconditional PC write enable
//   PCWriteCond  out  1  PC write enable qualified by ALU Zero (beq)
//   IorD         out  1  memory address select (0 = PC, 1 = ALUOut)
//   MemRead      out  1  memory read enable
//   MemWrite     out  1  memory write enable
//   MemtoReg     out  1  register write data select (0 = ALUOut, 1 = MDR)
//   IRWrite      out  1  instruction register load enable
//   PCSource     out  2  next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   ALUOp1       out  1  ALUOp MSB to ALU_control
//   ALUOp0       out  1  ALUOp LSB to ALU_control
//   ALUSrcA      out  1  ALU A select (0 = PC, 1 = register A)
//   ALUSrcB      out  2  ALU B select (00 B, 01 +4, 10 imm, 11 imm<<2)
//   RegWrite     out  1  register file write enable
//   RegDst       out  1  write register select (0 = rt, 1 = rd)
//   state        out  4  current state code, for debug
//   illegal_op   out  1  pulses in the DECODE cycle of an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state,
  output logic       illegal_op
);

  // State codes are visible on the debug port, so they are fixed values.
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXEC    = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] JUMP    = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Returns 1 for every opcode that DECODE dispatches to a real path.
  function automatic logic is_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [3:0] state_r;
  logic [3:0] next_state_s;

  // State register. Reset acts at once, even in the middle of an instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. Opcode only steers the DECODE and MEMADR branches.
  // Unused codes 10-15 fall into the default branch and return to FETCH.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: next_state_s = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = EXEC;
          OP_BEQ:       next_state_s = BRANCH;
          OP_J:         next_state_s = JUMP;
          default:      next_state_s = FETCH;
        endcase
      end
      MEMADR: begin
        // If opcode changed to a non-memory op since DECODE, drop the
        // instruction rather than guess which access was meant.
        case (opcode)
          OP_LW:   next_state_s = MEMRD;
          OP_SW:   next_state_s = MEMWR;
          default: next_state_s = FETCH;
        endcase
      end
      MEMRD:   next_state_s = MEMWB;
      MEMWB:   next_state_s = FETCH;
      MEMWR:   next_state_s = FETCH;
      EXEC:    next_state_s = RTYPEWB;
      RTYPEWB: next_state_s = FETCH;
      BRANCH:  next_state_s = FETCH;
      JUMP:    next_state_s = FETCH;
      default: next_state_s = FETCH;
    endcase
  end

  // Moore output decode. Every line defaults to 0, so each state only lists
  // the lines it asserts. Unused state codes keep all outputs at 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp1      = 1'b0;
    ALUOp0      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (state_r)
      FETCH: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        PCWrite  = 1'b1;
        PCSource = 2'b00;
      end
      DECODE: begin
        // Precompute the branch target as PC + (imm << 2).
        ALUSrcB = 2'b11;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp1  = 1'b1;
      end
      RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp0      = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  // Illegal-opcode flag. Only DECODE can raise it, so it lasts one cycle.
  always_comb begin
    if (state_r == DECODE && !is_supported(opcode)) begin
      illegal_op = 1'b1;
    end else begin
      illegal_op = 1'b0;
    end
  end

  assign state = state_r;

  multicycle_control_checker u_checker (
    .clk        (clk),
    .reset      (reset),
    .state      (state_r),
    .mem_read   (MemRead),
    .mem_write  (MemWrite),
    .alu_op1    (ALUOp1),
    .alu_op0    (ALUOp0),
    .illegal_op (illegal_op)
  );

endmodule

// -----------------------------------------------------------------------------
// multicycle_control_checker
//   Property checks on the control unit's outputs. Synthesis ignores it.
//
// Ports (all inputs)
//   clk, reset   clock and reset of the checked FSM
//   state        current state code
//   mem_read     MemRead output
//   mem_write    MemWrite output
//   alu_op1      ALUOp MSB output
//   alu_op0      ALUOp LSB output
//   illegal_op   illegal-opcode flag
// -----------------------------------------------------------------------------
module multicycle_control_checker (
  input logic       clk,
  input logic       reset,
  input logic [3:0] state,
  input logic       mem_read,
  input logic       mem_write,
  input logic       alu_op1,
  input logic       alu_op0,
  input logic       illegal_op
);

  a_no_rd_wr: assert property (@(posedge clk) disable iff (reset)
    !(mem_read && mem_write));

  a_aluop_legal: assert property (@(posedge clk) disable iff (reset)
    !(alu_op1 && alu_op0));

  a_illegal_in_decode: assert property (@(posedge clk) disable iff (reset)
    illegal_op |-> (state == 4'd1));

  a_unused_recovers: assert property (@(posedge clk) disable iff (reset)
    (state > 4'd9) |=> (state == 4'd0));

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. Each task runs one scenario and
//   compares state, the packed control vector and illegal_op against
//   hand-written tables. Sampling happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource;
  logic       ALUOp1, ALUOp0, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite, RegDst;
  logic [3:0] state;
  logic       illegal_op;

  int checks = 0;
  int errors = 0;

  // Control vector order:
  // {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
  //  PCSource[1:0], ALUOp1, ALUOp0, ALUSrcA, ALUSrcB[1:0], RegWrite, RegDst}
  localparam logic [15:0] C_FETCH   = 16'b1001_0010_0000_0100;
  localparam logic [15:0] C_DECODE  = 16'b0000_0000_0000_1100;
  localparam logic [15:0] C_MEMADR  = 16'b0000_0000_0001_1000;
  localparam logic [15:0] C_MEMRD   = 16'b0011_0000_0000_0000;
  localparam logic [15:0] C_MEMWB   = 16'b0000_0100_0000_0010;
  localparam logic [15:0] C_MEMWR   = 16'b0010_1000_0000_0000;
  localparam logic [15:0] C_EXEC    = 16'b0000_0000_0101_0000;
  localparam logic [15:0] C_RTYPEWB = 16'b0000_0000_0000_0011;
  localparam logic [15:0] C_BRANCH  = 16'b0100_0000_1011_0000;
  localparam logic [15:0] C_JUMP    = 16'b1000_0001_0000_0000;

  logic [15:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                 IRWrite, PCSource, ALUOp1, ALUOp0, ALUSrcA, ALUSrcB,
                 RegWrite, RegDst};

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .PCSource    (PCSource),
    .ALUOp1      (ALUOp1),
    .ALUOp0      (ALUOp0),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .state       (state),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset  = 1'b1;
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got %0d expected 0", i, state);
      end
      checks++;
      if (ctrl !== C_FETCH) begin
        errors++;
        $display("FAIL reset_ctrl cycle %0d: got %b expected %b", i, ctrl, C_FETCH);
      end
      checks++;
      if (illegal_op !== 1'b0) begin
        errors++;
        $display("FAIL reset_illegal cycle %0d: got %b expected 0", i, illegal_op);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] ec [6] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL lw_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL lw_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
      checks++;
      if (illegal_op !== 1'b0) begin
        errors++;
        $display("FAIL lw_illegal step %0d: got %b expected 0", i, illegal_op);
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [15:0] ec [5] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL sw_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL sw_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // R-type followed directly by beq; opcode switches at the shared FETCH.
    logic [3:0]  es [7] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8};
    logic [15:0] ec [7] = '{C_FETCH, C_DECODE, C_EXEC, C_RTYPEWB,
                            C_FETCH, C_DECODE, C_BRANCH};
    opcode = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) opcode = 6'b000100;
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL rtype_beq_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL rtype_beq_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL beq_return: got %0d expected 0", state);
    end
  endtask

  task automatic test_jump_illegal();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd0};
    logic [15:0] ec [6] = '{C_FETCH, C_DECODE, C_JUMP, C_FETCH, C_DECODE, C_FETCH};
    logic        ei [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b000010;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) opcode = 6'b111111;
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL j_ill_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL j_ill_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
      checks++;
      if (illegal_op !== ei[i]) begin
        errors++;
        $display("FAIL j_ill_flag step %0d: got %b expected %b", i, illegal_op, ei[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    opcode = 6'b100011;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 4'd3) begin
      errors++;
      $display("FAIL areset_setup: got %0d expected 3", state);
    end
    // Mid-cycle reset: posedge is 5 time units away; check before it.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL areset_state: got %0d expected 0", state);
    end
    checks++;
    if (ctrl !== C_FETCH) begin
      errors++;
      $display("FAIL areset_ctrl: got %b expected %b", ctrl, C_FETCH);
    end
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL areset_illegal: got %b expected 0", illegal_op);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL areset_hold: got %0d expected 0", state);
    end
    opcode = 6'b111111;
    reset  = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL areset_release: got %0d expected 1", state);
    end
    checks++;
    if (illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL areset_release_illegal: got %b expected 1", illegal_op);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL areset_back: got %0d expected 0", state);
    end
  endtask

  task automatic test_opcode_isolation();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] ec [6] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      // sw opcode in MEMRD, then junk in MEMWB: neither may steer the FSM.
      if (i == 3) opcode = 6'b101011;
      if (i == 4) opcode = 6'b000010;
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL iso_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL iso_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_jump_illegal();
    test_async_reset();
    test_opcode_isolation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
